pipe_seq_ctrl: RTL and testbench
================================

PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): CTRL_WIDTH, 8, packet control-word width; IMEM_ADDR_WIDTH, 9, instruction-memory address width; RUN_TIMEOUT, 1024, watchdog limit in RUN, in cycles.
REQ-002 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: clock.
- reset, in, 1: async active-high reset.
- in_wr, in, 1: packet word valid.
- in_ctrl, in, CTRL_WIDTH: packet control word.
- in_rdy, out, 1: packet word accepted.
- fifo_full, in, 1: pipeline packet FIFO full.
- cmd_valid, in, 1: software instruction word valid.
- cmd_addr, in, IMEM_ADDR_WIDTH: instruction address.
- cmd_data, in, 32: instruction word.
- cmd_last, in, 1: final instruction of the program.
- imem_wr_en, out, 1: instruction-memory write strobe.
- imem_wr_addr, out, IMEM_ADDR_WIDTH: instruction-memory write address.
- imem_wr_data, out, 32: instruction-memory write data.
- mode_code, out, 2: FIFO/memory mode; 00 = receive, 01 = send, 10 = memory.
- pipe_rst, out, 1: pipeline core reset.
- proc_done, in, 1: pipeline finished processing.
- send_done, in, 1: last packet word has left the FIFO.
- status, out, 32: state and counters.

Function
REQ-004 The FSM SHALL have five states with these encodings: IDLE = 0, RECV = 1, LOAD = 2, RUN = 3, SEND = 4. Unused encodings SHALL return to IDLE on the next cycle.
REQ-005 Transitions SHALL be:
- IDLE -> RECV unconditionally after 1 cycle.
- RECV -> LOAD on the accepted end-of-packet word.
- LOAD -> RUN on an accepted cmd_valid with cmd_last=1.
- RUN -> SEND on proc_done=1.
- SEND -> IDLE on send_done=1.
REQ-006 mode_code SHALL be registered: 00 in IDLE and RECV, 10 in LOAD and RUN, 01 in SEND.
REQ-007 in_rdy SHALL be combinational and equal (state==RECV) AND NOT fifo_full.
REQ-008 A word SHALL be accepted when in_wr and in_rdy are both 1.
REQ-009 A data-seen flag SHALL be set by an accepted word with in_ctrl==0.
REQ-010 End-of-packet SHALL be an accepted word with in_ctrl!=0 while the data-seen flag is set. The data-seen flag SHALL be cleared on leaving RECV.
REQ-011 A word with in_wr=1 while fifo_full=1 SHALL NOT be accepted and SHALL NOT affect packet detection.
REQ-012 In LOAD, each cmd_valid SHALL produce imem_wr_en=1 exactly one cycle later, with imem_wr_addr and imem_wr_data registered from cmd_addr and cmd_data.
REQ-013 cmd_valid outside LOAD SHALL be ignored. It SHALL increment a drop counter that saturates at 255.
REQ-014 pipe_rst SHALL be 1 in IDLE, RECV and LOAD, and SHALL be 0 from the first RUN cycle.
REQ-015 pipe_rst SHALL return to 1 on entry to IDLE.
REQ-016 If proc_done and a late cmd_valid coincide in RUN, the FSM SHALL take proc_done and count the cmd_valid as dropped.
REQ-017 The 16-bit packet counter SHALL increment on each SEND -> IDLE transition and SHALL wrap from 0xFFFF to 0x0000.
REQ-018 status SHALL be: [2:0] state, [3] sticky timeout flag, [7:4] zero, [15:8] drop counter, [31:16] packet counter.

Reset
REQ-019 On reset assertion the block SHALL, asynchronously: set state to IDLE, mode_code to 00, pipe_rst to 1, imem_wr_en to 0, imem_wr_addr to 0 and imem_wr_data to 0.
REQ-020 On reset assertion the block SHALL clear all counters, the timeout flag and the data-seen flag.
REQ-021 Reset asserted mid-packet or mid-LOAD SHALL discard progress; no imem write SHALL issue after reset asserts.
REQ-022 Operation SHALL resume on the first clock edge after reset deasserts.

Configuration
REQ-023 With macro PIPE_SEQ_CTRL_WATCHDOG_EN defined, a RUN cycle counter SHALL force RUN -> SEND after RUN_TIMEOUT cycles without proc_done.
REQ-024 The forced transition SHALL set status[3]; status[3] SHALL be cleared only by reset.
REQ-025 Without the macro, RUN SHALL wait indefinitely for proc_done, and status[3] SHALL read 0.

Verification
REQ-026 Single packet: words with ctrl FF, 00, 00, 01, then 3 cmd words with the last flagged, then proc_done, then send_done -> mode_code sequence 00, 10, 01, 00; 3 imem writes to addresses 0..2; status[31:16]=1.
REQ-027 Backpressure: fifo_full=1 for 5 cycles mid-packet with in_wr held -> in_rdy=0 for those 5 cycles; no early LOAD; the packet completes after fifo_full drops.
REQ-028 Stray commands: 4 cmd_valid pulses in RECV -> status[15:8]=4 and no imem_wr_en. Drive 300 pulses -> status[15:8]=255.
REQ-029 Reset mid-LOAD after 2 of 5 commands -> state IDLE, pipe_rst=1 immediately; no further imem writes.
REQ-030 With PIPE_SEQ_CTRL_WATCHDOG_EN and RUN_TIMEOUT=16, proc_done withheld -> SEND entered after 16 RUN cycles and status[3]=1. Without the macro, the FSM stays in RUN.
REQ-031 Counter wrap: preload the packet count to 0xFFFF via 65535 packets (or force) and run one more packet -> status[31:16]=0.

Source files
------------

// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: receive a packet, load the instruction memory, run the core, then send the result.
// Optional RUN watchdog is enabled by defining PIPE_SEQ_CTRL_WATCHDOG_EN.
module pipe_seq_ctrl #(
  parameter int CTRL_WIDTH      = 8,
  parameter int IMEM_ADDR_WIDTH = 9,
  parameter int RUN_TIMEOUT     = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_wr,
  input  logic [CTRL_WIDTH-1:0]      in_ctrl,
  output logic                       in_rdy,
  input  logic                       fifo_full,
  input  logic                       cmd_valid,
  input  logic [IMEM_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]                cmd_data,
  input  logic                       cmd_last,
  output logic                       imem_wr_en,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_wr_addr,
  output logic [31:0]                imem_wr_data,
  output logic [1:0]                 mode_code,
  output logic                       pipe_rst,
  input  logic                       proc_done,
  input  logic                       send_done,
  output logic [31:0]                status
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RECV = 3'd1,
    LOAD = 3'd2,
    RUN  = 3'd3,
    SEND = 3'd4
  } state_t;

  state_t                     state_r;
  state_t                     next_state_s;
  logic                       data_seen_r;
  logic                       accept_s;
  logic                       eop_s;
  logic                       prog_end_s;
  logic                       drop_s;
  logic                       send_end_s;
  logic                       run_expired_s;
  logic                       timeout_s;
  logic [1:0]                 mode_r;
  logic                       pipe_rst_r;
  logic                       imem_wr_en_r;
  logic [IMEM_ADDR_WIDTH-1:0] imem_wr_addr_r;
  logic [31:0]                imem_wr_data_r;
  logic [7:0]                 drop_cnt_r;
  logic [15:0]                pkt_cnt_r;

  // FIFO/memory mode seen by the datapath for a given state.
  function automatic logic [1:0] mode_for(input state_t s);
    case (s)
      LOAD, RUN: mode_for = 2'b10;
      SEND:      mode_for = 2'b01;
      default:   mode_for = 2'b00;
    endcase
  endfunction

  assign in_rdy     = (state_r == RECV) && !fifo_full;
  assign accept_s   = in_wr && in_rdy;
  // A non-zero control word only closes the packet once a data word has gone by.
  assign eop_s      = accept_s && (in_ctrl != {CTRL_WIDTH{1'b0}}) && data_seen_r;
  assign prog_end_s = (state_r == LOAD) && cmd_valid && cmd_last;
  assign drop_s     = cmd_valid && (state_r != LOAD);
  assign send_end_s = (state_r == SEND) && send_done;

`ifdef PIPE_SEQ_CTRL_WATCHDOG_EN
  localparam int RUN_CNT_W = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;

  logic [RUN_CNT_W-1:0] run_cnt_r;
  logic                 timeout_r;

  assign run_expired_s = (run_cnt_r == RUN_CNT_W'(RUN_TIMEOUT - 1));
  assign timeout_s     = timeout_r;

  // RUN cycle counter and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt_r <= {RUN_CNT_W{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      if (state_r == RUN) begin
        run_cnt_r <= run_cnt_r + {{(RUN_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        run_cnt_r <= {RUN_CNT_W{1'b0}};
      end
      if ((state_r == RUN) && !proc_done && run_expired_s) begin
        timeout_r <= 1'b1;
      end
    end
  end
`else
  assign run_expired_s = 1'b0;
  assign timeout_s     = 1'b0;
`endif

  // Next-state logic; proc_done has priority over any late command.
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE: next_state_s = RECV;
      RECV: begin
        if (eop_s) next_state_s = LOAD;
        else       next_state_s = RECV;
      end
      LOAD: begin
        if (prog_end_s) next_state_s = RUN;
        else            next_state_s = LOAD;
      end
      RUN: begin
        if (proc_done)          next_state_s = SEND;
        else if (run_expired_s) next_state_s = SEND;
        else                    next_state_s = RUN;
      end
      SEND: begin
        if (send_done) next_state_s = IDLE;
        else           next_state_s = SEND;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register plus mode/pipe_rst registered from the next state so they track it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      mode_r     <= 2'b00;
      pipe_rst_r <= 1'b1;
    end else begin
      state_r    <= next_state_s;
      mode_r     <= mode_for(next_state_s);
      pipe_rst_r <= !((next_state_s == RUN) || (next_state_s == SEND));
    end
  end

  // Data-seen flag for end-of-packet detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_seen_r <= 1'b0;
    end else if ((state_r != RECV) || eop_s) begin
      data_seen_r <= 1'b0;
    end else if (accept_s && (in_ctrl == {CTRL_WIDTH{1'b0}})) begin
      data_seen_r <= 1'b1;
    end else begin
      data_seen_r <= data_seen_r;
    end
  end

  // Instruction-memory write port, one cycle behind the accepted command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_wr_en_r   <= 1'b0;
      imem_wr_addr_r <= {IMEM_ADDR_WIDTH{1'b0}};
      imem_wr_data_r <= 32'd0;
    end else begin
      imem_wr_en_r <= (state_r == LOAD) && cmd_valid;
      if ((state_r == LOAD) && cmd_valid) begin
        imem_wr_addr_r <= cmd_addr;
        imem_wr_data_r <= cmd_data;
      end
    end
  end

  // Saturating drop counter and wrapping packet counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_r <= 8'd0;
      pkt_cnt_r  <= 16'd0;
    end else begin
      if (drop_s && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
      if (send_end_s) begin
        pkt_cnt_r <= pkt_cnt_r + 16'd1;
      end
    end
  end

  assign imem_wr_en   = imem_wr_en_r;
  assign imem_wr_addr = imem_wr_addr_r;
  assign imem_wr_data = imem_wr_data_r;
  assign mode_code    = mode_r;
  assign pipe_rst     = pipe_rst_r;
  assign status       = {pkt_cnt_r, drop_cnt_r, 4'b0000, timeout_s, state_r};

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Self-checking bench for pipe_seq_ctrl: abstract per-cycle model plus directed scenarios.
module tb_pipe_seq_ctrl;
  localparam int CW = 8;
  localparam int AW = 9;
  localparam int TO = 16;
  localparam int S_IDLE = 0, S_RECV = 1, S_LOAD = 2, S_RUN = 3, S_SEND = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_wr = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic          in_rdy;
  logic          fifo_full = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_data = 32'd0;
  logic          cmd_last = 1'b0;
  logic          imem_wr_en;
  logic [AW-1:0] imem_wr_addr;
  logic [31:0]   imem_wr_data;
  logic [1:0]    mode_code;
  logic          pipe_rst;
  logic          proc_done = 1'b0;
  logic          send_done = 1'b0;
  logic [31:0]   status;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b1;
  bit pre_ld = 1'b0;

  always #5 clk = ~clk;

  pipe_seq_ctrl #(.CTRL_WIDTH(CW), .IMEM_ADDR_WIDTH(AW), .RUN_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_wr(in_wr), .in_ctrl(in_ctrl), .in_rdy(in_rdy),
    .fifo_full(fifo_full), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_last(cmd_last), .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data), .mode_code(mode_code), .pipe_rst(pipe_rst),
    .proc_done(proc_done), .send_done(send_done), .status(status)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase, flags and counters updated from the rules each clock.
  int            m_phase = S_IDLE;
  bit            m_seen = 1'b0;
  bit            m_to = 1'b0;
  int            m_drops = 0;
  int            m_pkts = 0;
  int            m_run = 0;
  bit            m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0]   m_data = 32'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = S_IDLE; m_seen = 0; m_to = 0; m_drops = 0; m_pkts = 0;
      m_run = 0; m_wr = 0; m_addr = '0; m_data = 32'd0;
    end else begin
      if (pre_ld) m_pkts = 16'hFFFF;
      m_wr = (m_phase == S_LOAD) && cmd_valid;
      if (m_wr) begin m_addr = cmd_addr; m_data = cmd_data; end
      if (cmd_valid && m_phase != S_LOAD && m_drops < 255) m_drops++;
      case (m_phase)
        S_IDLE: m_phase = S_RECV;
        S_RECV: if (in_wr && !fifo_full) begin
          if (in_ctrl == 0) m_seen = 1;
          else if (m_seen) begin m_phase = S_LOAD; m_seen = 0; end
        end
        S_LOAD: if (cmd_valid && cmd_last) begin m_phase = S_RUN; m_run = 0; end
        S_RUN: begin
          m_run++;
          if (proc_done) m_phase = S_SEND;
`ifdef PIPE_SEQ_CTRL_WATCHDOG_EN
          else if (m_run >= TO) begin m_phase = S_SEND; m_to = 1; end
`endif
        end
        S_SEND: if (send_done) begin m_phase = S_IDLE; m_pkts = (m_pkts + 1) % 65536; end
        default: m_phase = S_IDLE;
      endcase
    end
  end

  // Compare process plus write/mode observation logs.
  int         n_wr = 0;
  logic [8:0] wr_log[$];
  logic [1:0] mode_log[$];
  logic [1:0] last_mode = 2'b00;

  always @(negedge clk) begin
    logic [1:0] em;
    if (chk_en) begin
      em = (m_phase == S_SEND) ? 2'b01 : (m_phase == S_LOAD || m_phase == S_RUN) ? 2'b10 : 2'b00;
      chk("state", {29'd0, status[2:0]}, m_phase);
      chk("mode_code", {30'd0, mode_code}, {30'd0, em});
      chk("pipe_rst", {31'd0, pipe_rst}, (m_phase == S_RUN || m_phase == S_SEND) ? 0 : 1);
      chk("in_rdy", {31'd0, in_rdy}, (m_phase == S_RECV && !fifo_full) ? 1 : 0);
      chk("imem_wr_en", {31'd0, imem_wr_en}, {31'd0, m_wr});
      chk("imem_wr_addr", {23'd0, imem_wr_addr}, {23'd0, m_addr});
      chk("imem_wr_data", imem_wr_data, m_data);
      chk("status", status, {m_pkts[15:0], m_drops[7:0], 4'b0000, m_to, m_phase[2:0]});
    end
    if (imem_wr_en) begin n_wr++; wr_log.push_back(imem_wr_addr); end
    if (mode_code != last_mode) begin mode_log.push_back(mode_code); last_mode = mode_code; end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_state(input int s, input string name);
    int n = 0;
    while (status[2:0] != s[2:0] && n < 200) begin step(); n++; end
    chk({"reach_", name}, {29'd0, status[2:0]}, s);
  endtask

  task automatic send_word(input logic [CW-1:0] c);
    in_wr = 1'b1; in_ctrl = c; step(); in_wr = 1'b0; in_ctrl = '0;
  endtask

  task automatic recv_packet();
    wait_state(S_RECV, "recv");
    send_word(8'hFF); send_word(8'h00); send_word(8'h00); send_word(8'h01);
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1'b1; cmd_addr = AW'(i); cmd_data = 32'hC0DE_0000 | i; cmd_last = (i == n - 1);
      step();
    end
    cmd_valid = 1'b0; cmd_last = 1'b0;
  endtask

  task automatic finish_pkt();
    proc_done = 1'b1; step(); proc_done = 1'b0;
    wait_state(S_SEND, "send");
    send_done = 1'b1; step(); send_done = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wb, mb, n;
    repeat (2) step();
    chk("rst_status", status, 32'd0);
    chk("rst_mode", {30'd0, mode_code}, 32'd0);
    chk("rst_pipe_rst", {31'd0, pipe_rst}, 32'd1);
    chk("rst_imem_wr_en", {31'd0, imem_wr_en}, 32'd0);
    reset = 1'b0;

    // Single packet.
    wb = n_wr; mb = mode_log.size();
    recv_packet();
    chk("pkt1_in_load", {29'd0, status[2:0]}, S_LOAD);
    load_prog(3);
    chk("pkt1_in_run", {29'd0, status[2:0]}, S_RUN);
    chk("pkt1_pipe_rst_run", {31'd0, pipe_rst}, 32'd0);
    finish_pkt();
    @(negedge clk); #1;
    chk("pkt1_count", {16'd0, status[31:16]}, 32'd1);
    chk("pkt1_writes", n_wr - wb, 32'd3);
    for (int i = 0; i < 3; i++) chk("pkt1_wr_addr", {23'd0, wr_log[wb + i]}, i);
    chk("pkt1_mode_changes", mode_log.size() - mb, 32'd3);
    if (mode_log.size() - mb == 3) begin
      chk("pkt1_mode0", {30'd0, mode_log[mb]}, 32'd2);
      chk("pkt1_mode1", {30'd0, mode_log[mb + 1]}, 32'd1);
      chk("pkt1_mode2", {30'd0, mode_log[mb + 2]}, 32'd0);
    end

    // Backpressure mid-packet.
    wait_state(S_RECV, "bp_recv");
    send_word(8'hFF); send_word(8'h00);
    in_wr = 1'b1; in_ctrl = 8'h01; fifo_full = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_rdy", {31'd0, in_rdy}, 32'd0);
      chk("bp_no_load", {29'd0, status[2:0]}, S_RECV);
      step();
    end
    fifo_full = 1'b0; #1;
    chk("bp_in_rdy_back", {31'd0, in_rdy}, 32'd1);
    step(); in_wr = 1'b0; in_ctrl = '0;
    chk("bp_load", {29'd0, status[2:0]}, S_LOAD);
    load_prog(1);
    finish_pkt();
    chk("bp_count", {16'd0, status[31:16]}, 32'd2);

    // Stray commands outside LOAD.
    wait_state(S_RECV, "stray_recv");
    wb = n_wr;
    for (int i = 0; i < 4; i++) begin cmd_valid = 1'b1; step(); cmd_valid = 1'b0; step(); end
    chk("stray_drops4", {24'd0, status[15:8]}, 32'd4);
    chk("stray_no_write", n_wr - wb, 32'd0);
    cmd_valid = 1'b1;
    repeat (300) step();
    cmd_valid = 1'b0;
    chk("stray_drops_sat", {24'd0, status[15:8]}, 32'd255);
    chk("stray_still_recv", {29'd0, status[2:0]}, S_RECV);

    // Reset mid-LOAD after 2 of 5 commands.
    send_word(8'hFF); send_word(8'h00); send_word(8'h01);
    chk("rl_in_load", {29'd0, status[2:0]}, S_LOAD);
    wb = n_wr;
    for (int i = 0; i < 2; i++) begin
      cmd_valid = 1'b1; cmd_addr = AW'(i); cmd_data = 32'h5A00_0000 | i; step();
    end
    cmd_valid = 1'b0; step();
    cmd_valid = 1'b1; cmd_addr = 9'd2; reset = 1'b1; #1;
    chk("rl_state", {29'd0, status[2:0]}, S_IDLE);
    chk("rl_pipe_rst", {31'd0, pipe_rst}, 32'd1);
    chk("rl_wr_en", {31'd0, imem_wr_en}, 32'd0);
    chk("rl_status", status, 32'd0);
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();
    cmd_valid = 1'b0;
    repeat (2) step();
    chk("rl_writes", n_wr - wb, 32'd2);

    // Watchdog.
    recv_packet();
    load_prog(1);
    n = 0;
    while (status[2:0] == 3'd3 && n < 40) begin n++; step(); end
`ifdef PIPE_SEQ_CTRL_WATCHDOG_EN
    chk("wd_run_cycles", n, TO);
    chk("wd_send", {29'd0, status[2:0]}, S_SEND);
    chk("wd_flag", {31'd0, status[3]}, 32'd1);
`else
    chk("wd_run_cycles", n, 32'd40);
    chk("wd_still_run", {29'd0, status[2:0]}, S_RUN);
    chk("wd_flag", {31'd0, status[3]}, 32'd0);
`endif
    finish_pkt();

    // Packet counter wrap.
    wait_state(S_RECV, "wrap_recv");
    chk_en = 1'b0;
    force dut.pkt_cnt_r = 16'hFFFF;
    #1 release dut.pkt_cnt_r;
    pre_ld = 1'b1; step(); pre_ld = 1'b0;
    chk_en = 1'b1;
    chk("wrap_preload", {16'd0, status[31:16]}, 32'h0000_FFFF);
    recv_packet();
    load_prog(2);
    finish_pkt();
    chk("wrap_count", {16'd0, status[31:16]}, 32'd0);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
